// File: rtl/serial_out_tx.sv
// serial_out_tx
//   Byte-wide 8N1 serial transmitter fed by the parallel output port strobe.
//   A one-byte holding buffer absorbs a second store issued mid-frame; any
//   further store while the buffer is full is dropped and flagged.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   Start    write strobe, one request per cycle it is high
//   DataIn   byte to send, sampled when Start=1
//   ClrOvr   synchronous clear of Overrun
//   Tx       serial line, idle high
//   Busy     frame in progress (START, DATA or STOP)
//   Pending  holding buffer occupied
//   Overrun  sticky flag: a byte was dropped
module serial_out_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic [7:0] DataIn,
  input  logic       ClrOvr,
  output logic       Tx,
  output logic       Busy,
  output logic       Pending,
  output logic       Overrun
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;

  logic          bit_end;
  logic          stop_end;
  logic          ovr_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    hold_d   = hold_q;
    pend_d   = pend_q;
    ovr_set  = 1'b0;
    bit_end  = (cnt_q == CNT_LAST);
    stop_end = (state_q == STOP) && bit_end;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          shift_d = DataIn;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Buffered byte has priority over a coincident Start so order is kept.
        if (bit_end) begin
          if (pend_q) begin
            shift_d = hold_q;
            state_d = START;
          end else if (Start) begin
            shift_d = DataIn;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // On the final STOP cycle the buffer is draining, so a coincident Start
    // refills it instead of counting as an overrun.
    if (state_q != IDLE && Start) begin
      if (stop_end) begin
        if (pend_q) hold_d = DataIn;
      end else if (!pend_q) begin
        hold_d = DataIn;
        pend_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    if (stop_end && pend_q && !Start) pend_d = 1'b0;

    ovr_d = ovr_set | (ovr_q & ~ClrOvr);
  end

  always_comb begin
    unique case (state_q)
      START:   Tx = 1'b0;
      DATA:    Tx = shift_q[0];
      default: Tx = 1'b1;
    endcase
  end

  assign Busy    = (state_q != IDLE);
  assign Pending = pend_q;
  assign Overrun = ovr_q;

endmodule
